// File: rtl/hack_boot_pkg.sv
// Shared types for the Hack CPU boot loader: loader FSM states and word width.
package hack_boot_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    SUM_HI,
    SUM_LO,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins a big-endian byte pair into one word; strobes on the accepted low byte.
module byte_pair_assembler
  import hack_boot_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              byte_stb,
  input  logic              lo_phase,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_stb
);

  logic [7:0] hi_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
    end else if (byte_stb && !lo_phase) begin
      hi_q <= byte_in;
    end
  end

  // The word is only meaningful while word_stb is high; the low byte passes straight through.
  assign word     = {hi_q, byte_in};
  assign word_stb = byte_stb && lo_phase;

endmodule

// File: rtl/hack_boot_loader.sv
// Holds the Hack CPU in reset, streams a counted, checksummed program into ROM, then releases the CPU.
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              reload,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              err,
  output state_t            state_dbg
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready and reload is low.
  // rx_ready depends only on state, so it never combinationally follows rx_valid.

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] count;
  logic [WORD_W-1:0] word;
  logic              accept, lo_phase, word_stb;
  logic              last_word, hdr_too_big;

  assign rx_ready  = (state != RUN) && (state != ERR);
  assign accept    = rx_valid && rx_ready && !reload;
  assign lo_phase  = (state == HDR_LO) || (state == DATA_LO) || (state == SUM_LO);
  assign cpu_reset = (state != RUN);
  assign load_done = (state == RUN);
  assign err       = (state == ERR);
  assign state_dbg = state;

  // Index is one bit wider than the address so a full 2^ADDR_W load never wraps.
  assign idx_inc     = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word   = (33'(idx_inc) == 33'(count));
  assign hdr_too_big = (33'(word) > CAPACITY);

  byte_pair_assembler u_pair (
    .CLK      (CLK),
    .reset    (reset),
    .byte_stb (accept),
    .lo_phase (lo_phase),
    .byte_in  (rx_data),
    .word     (word),
    .word_stb (word_stb)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= HDR_HI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = HDR_HI;
    end else if (accept) begin
      case (state)
        HDR_HI:  state_nxt = HDR_LO;
        HDR_LO:  begin
          if (word == '0)       state_nxt = SUM_HI;
          else if (hdr_too_big) state_nxt = ERR;
          else                  state_nxt = DATA_HI;
        end
        DATA_HI: state_nxt = DATA_LO;
        DATA_LO: state_nxt = last_word ? SUM_HI : DATA_HI;
        SUM_HI:  state_nxt = SUM_LO;
        SUM_LO:  state_nxt = (word == sum) ? RUN : ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      sum       <= '0;
      count     <= '0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      rom_we    <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      if (reload) begin
        idx <= '0;
        sum <= '0;
      end else if (word_stb) begin
        case (state)
          HDR_LO:  count <= word;
          DATA_LO: begin
            rom_addr  <= idx[ADDR_W-1:0];
            rom_wdata <= word;
            rom_we    <= 1'b1;
            sum       <= sum + word;
            idx       <= idx_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: frame loads, checksum errors, header limits, gaps, reload and async reset.
module tb_hack_boot_loader;
  import hack_boot_pkg::*;

  localparam int ADDR_W = 15;

  logic              CLK = 1'b0;
  logic              reset;
  logic              reload;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              rom_we;
  logic              cpu_reset;
  logic              load_done;
  logic              err;
  state_t            state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  logic [30:0] exp_q[$];
  logic [15:0] words[4];

  hack_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .reload    (reload),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .rom_we    (rom_we),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ROM write must match the next expected {addr, data}
  always @(negedge CLK) begin
    if (rom_we) begin
      n_writes++;
      if (exp_q.size() == 0) check("rom_we_unexpected", 32'(rom_we), 32'd0);
      else check("rom_write", 32'({rom_addr, rom_wdata}), 32'(exp_q.pop_front()));
    end
  end

  // Drivers: all called and returning at a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap_max);
    send_byte(w[15:8], gap_max);
    send_byte(w[7:0], gap_max);
  endtask

  task automatic send_frame(input int n, input logic [15:0] csum, input int gap_max);
    send_word(16'(n), gap_max);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), words[i]});
      send_word(words[i], gap_max);
    end
    send_word(csum, gap_max);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
  endtask

  task automatic set_frame_a();
    words[0] = 16'h7FFF;
    words[1] = 16'hEC10;
    words[2] = 16'h1000;
    words[3] = 16'hE308;
  endtask

  initial begin
    reset    = 1'b1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    set_frame_a();
    #1;
    check("rst_rx_ready",  32'(rx_ready),  32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rom_we",    32'(rom_we),    32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err",       32'(err),       32'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    // N=4 back-to-back; the four words sum to 0x5F17 mod 2^16
    n_writes = 0;
    send_frame(4, 16'h5F17, 0);
    check("t1_load_done", 32'(load_done), 32'd1);
    check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t1_rx_ready",  32'(rx_ready),  32'd0);
    check("t1_writes",    32'(n_writes),  32'd4);

    // Same frame with a wrong checksum
    pulse_reload();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_load_done", 32'(load_done), 32'd0);
    n_writes = 0;
    send_frame(4, 16'h6B28, 0);
    check("t2_err",       32'(err),       32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_rx_ready",  32'(rx_ready),  32'd0);
    check("t2_load_done", 32'(load_done), 32'd0);
    check("t2_writes",    32'(n_writes),  32'd4);

    // Empty program: checksum 0 must match
    pulse_reload();
    n_writes = 0;
    send_frame(0, 16'h0000, 0);
    check("t3_load_done", 32'(load_done), 32'd1);
    check("t3_writes",    32'(n_writes),  32'd0);

    // Header one past capacity errors on its low byte
    pulse_reload();
    send_word(16'h8001, 0);
    check("t4_err",      32'(err),      32'd1);
    check("t4_rx_ready", 32'(rx_ready), 32'd0);

    // Header exactly at capacity is accepted
    pulse_reload();
    send_word(16'h8000, 0);
    check("t4b_err",   32'(err),       32'd0);
    check("t4b_state", 32'(state_dbg), 32'(DATA_HI));

    // Random gaps between bytes
    pulse_reload();
    n_writes = 0;
    send_frame(4, 16'h5F17, 7);
    check("t5_load_done", 32'(load_done), 32'd1);
    check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t5_writes",    32'(n_writes),  32'd4);

    // Reload colliding with the low byte of word 2
    pulse_reload();
    n_writes = 0;
    send_word(16'd4, 0);
    exp_q.push_back({ADDR_W'(0), words[0]});
    send_word(words[0], 0);
    exp_q.push_back({ADDR_W'(1), words[1]});
    send_word(words[1], 0);
    send_byte(words[2][15:8], 0);
    check("t6_pre_state", 32'(state_dbg), 32'(DATA_LO));
    rx_valid = 1'b1;
    rx_data  = words[2][7:0];
    reload   = 1'b1;
    @(negedge CLK);
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("t6_state",     32'(state_dbg), 32'(HDR_HI));
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_rom_we",    32'(rom_we),    32'd0);
    check("t6_writes",    32'(n_writes),  32'd2);
    words[0] = 16'h0001;
    words[1] = 16'h0002;
    words[2] = 16'h0003;
    send_frame(3, 16'h0006, 0);
    check("t6_load_done", 32'(load_done), 32'd1);
    check("t6_writes2",   32'(n_writes),  32'd5);

    // Async reset in RUN, asserted between edges
    #2;
    reset = 1'b1;
    #1;
    check("ar_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ar_load_done", 32'(load_done), 32'd0);
    check("ar_err",       32'(err),       32'd0);
    check("ar_rx_ready",  32'(rx_ready),  32'd1);
    check("ar_rom_we",    32'(rom_we),    32'd0);
    check("ar_rom_addr",  32'(rom_addr),  32'd0);
    check("ar_rom_wdata", 32'(rom_wdata), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
